// File: rtl/univ_shift_reg.sv
// Width-generic universal shift register with a counted, handshaked multi-step shift.
// Optional build macro USR_SERIAL_IN_EN: SRL/SLL take their fill bit from sin_r/sin_l instead of 0.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_SRL   = 3'b001;
    localparam logic [2:0] OP_SLL   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_ROR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_SRA   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [AMT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_op, w_op_nxt;
    logic             r_done, w_done_nxt;
    logic             w_fill_r;
    logic             w_fill_l;

`ifdef USR_SERIAL_IN_EN
    assign w_fill_r = sin_r;
    assign w_fill_l = sin_l;
`else
    logic w_unused_sin;
    assign w_unused_sin = sin_r ^ sin_l;
    assign w_fill_r     = 1'b0;
    assign w_fill_l     = 1'b0;
`endif

    function automatic logic f_is_shift(input logic [2:0] f_op);
        return (f_op == OP_SRL) || (f_op == OP_SLL) || (f_op == OP_ROR) ||
               (f_op == OP_ROL) || (f_op == OP_SRA);
    endfunction

    // One single-bit step of the given shift/rotate op.
    function automatic logic [WIDTH-1:0] f_step(input logic [2:0]       f_op,
                                                input logic [WIDTH-1:0] f_q,
                                                input logic             f_fr,
                                                input logic             f_fl);
        logic [WIDTH-1:0] v;
        v = f_q;
        case (f_op)
            OP_SRL:  v = {f_fr, f_q[WIDTH-1:1]};
            OP_SLL:  v = {f_q[WIDTH-2:0], f_fl};
            OP_ROR:  v = {f_q[0], f_q[WIDTH-1:1]};
            OP_ROL:  v = {f_q[WIDTH-2:0], f_q[WIDTH-1]};
            OP_SRA:  v = {f_q[WIDTH-1], f_q[WIDTH-1:1]};
            default: v = f_q;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_op    <= OP_NOP;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (f_is_shift(op)) begin
                        if (amt == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            // First step happens on the accept edge itself.
                            w_q_nxt   = f_step(op, r_q, w_fill_r, w_fill_l);
                            w_op_nxt  = op;
                            w_cnt_nxt = amt - AMT_W'(1);
                            if (amt == AMT_W'(1)) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_state_nxt = S_SHIFT;
                            end
                        end
                    end else begin
                        case (op)
                            OP_LOAD:  w_q_nxt = din;
                            OP_CLEAR: w_q_nxt = '0;
                            default:  w_q_nxt = r_q;
                        endcase
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                w_q_nxt   = f_step(r_op, r_q, w_fill_r, w_fill_l);
                w_cnt_nxt = r_cnt - AMT_W'(1);
                if (r_cnt == AMT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign q         = r_q;
    assign busy      = (r_state == S_SHIFT);
    assign done      = r_done;
    assign cmd_ready = ~busy;
    assign sout_r    = r_q[0];
    assign sout_l    = r_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, AMT_W=4) with hand-computed expectations.
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_SRL   = 3'b001;
    localparam logic [2:0] OP_SLL   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_ROR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_SRA   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] din;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    univ_shift_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .op       (op),
        .amt      (amt),
        .din      (din),
        .sin_r    (sin_r),
        .sin_l    (sin_l),
        .q        (q),
        .sout_r   (sout_r),
        .sout_l   (sout_l),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge; caller is positioned just after an edge.
    task automatic issue(input logic [2:0] c_op, input logic [AMT_W-1:0] c_amt,
                         input logic [WIDTH-1:0] c_din);
        cmd_valid = 1'b1;
        op        = c_op;
        amt       = c_amt;
        din       = c_din;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        op        = OP_NOP;
        amt       = '0;
        din       = '0;
        sin_r     = 1'b0;
        sin_l     = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst_q", 32'(q), 32'h00);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_sout_r", 32'(sout_r), 0);
        check("rst_sout_l", 32'(sout_l), 0);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        issue(OP_LOAD, '0, 8'hFF);
        check("pre_async_q", 32'(q), 32'hFF);
        #2 rst = 1'b1;
        #1;
        check("async_q", 32'(q), 32'h00);
        check("async_done", 32'(done), 0);
        check("async_ready", 32'(cmd_ready), 1);
        rst = 1'b0;
        step();

        // LOAD then ROR by 3.
        issue(OP_LOAD, '0, 8'h81);
        check("load_q", 32'(q), 32'h81);
        check("load_done", 32'(done), 1);
        check("load_busy", 32'(busy), 0);
        issue(OP_ROR, 4'd3, 8'h00);
        check("ror1_q", 32'(q), 32'hC0);
        check("ror1_busy", 32'(busy), 1);
        check("ror1_ready", 32'(cmd_ready), 0);
        check("ror1_done", 32'(done), 0);
        step();
        check("ror2_q", 32'(q), 32'h60);
        check("ror2_busy", 32'(busy), 1);
        check("ror2_done", 32'(done), 0);
        step();
        check("ror3_q", 32'(q), 32'h30);
        check("ror3_busy", 32'(busy), 0);
        check("ror3_done", 32'(done), 1);
        check("ror3_ready", 32'(cmd_ready), 1);
        step();
        check("ror_done_low", 32'(done), 0);

        // SRA by 2.
        issue(OP_LOAD, '0, 8'h90);
        issue(OP_SRA, 4'd2, 8'h00);
        check("sra1_q", 32'(q), 32'hC8);
        check("sra1_done", 32'(done), 0);
        step();
        check("sra2_q", 32'(q), 32'hE4);
        check("sra2_done", 32'(done), 1);

        // SLL by 1 with sin_l high.
        issue(OP_LOAD, '0, 8'h81);
        sin_l = 1'b1;
        issue(OP_SLL, 4'd1, 8'h00);
        sin_l = 1'b0;
`ifdef USR_SERIAL_IN_EN
        check("sll_q", 32'(q), 32'h03);
`else
        check("sll_q", 32'(q), 32'h02);
`endif
        check("sll_sout_l", 32'(sout_l), 0);
        check("sll_done", 32'(done), 1);
        check("sll_busy", 32'(busy), 0);

        // SRL by 4 with a LOAD held pending while busy.
        issue(OP_LOAD, '0, 8'hA5);
        issue(OP_SRL, 4'd4, 8'h00);
        check("srl1_q", 32'(q), 32'h52);
        cmd_valid = 1'b1;
        op        = OP_LOAD;
        din       = 8'h55;
        step();
        check("srl2_q", 32'(q), 32'h29);
        check("srl2_sout_r", 32'(sout_r), 1);
        step();
        check("srl3_q", 32'(q), 32'h14);
        step();
        check("srl4_q", 32'(q), 32'h0A);
        check("srl4_done", 32'(done), 1);
        check("srl4_ready", 32'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        check("b2b_q", 32'(q), 32'h55);
        check("b2b_done", 32'(done), 1);

        // Shift by zero: no change, immediate completion.
        issue(OP_SRL, 4'd0, 8'h00);
        check("amt0_q", 32'(q), 32'h55);
        check("amt0_done", 32'(done), 1);
        check("amt0_busy", 32'(busy), 0);

        // Reset during SRL by 5, after two steps.
        issue(OP_LOAD, '0, 8'hFF);
        issue(OP_SRL, 4'd5, 8'h00);
        step();
        check("mid_q", 32'(q), 32'h3F);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_q", 32'(q), 32'h00);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(cmd_ready), 1);
        rst = 1'b0;
        step();
        check("mid_no_done", 32'(done), 0);
        step();
        check("mid_no_done2", 32'(done), 0);
        issue(OP_LOAD, '0, 8'h3C);
        check("post_load_q", 32'(q), 32'h3C);
        check("post_load_done", 32'(done), 1);

        // ROL by 9 wraps to a single-bit rotate.
        issue(OP_ROL, 4'd9, 8'h00);
        cyc = 1;
        while (!done && cyc < 20) begin
            step();
            cyc++;
        end
        check("rol9_cycles", 32'(cyc), 9);
        check("rol9_q", 32'(q), 32'h78);

        // NOP then CLEAR.
        issue(OP_NOP, 4'd3, 8'hAA);
        check("nop_q", 32'(q), 32'h78);
        check("nop_done", 32'(done), 1);
        issue(OP_CLEAR, '0, 8'hAA);
        check("clear_q", 32'(q), 32'h00);
        check("clear_done", 32'(done), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register with a command handshake: loads, clears, and logical, arithmetic and rotate shifts in either direction. A multi-step shift of `amt` single-bit steps runs one step per clock under a small busy/done controller. It sits between a control sequencer and a serial/parallel datapath, replacing the fixed 4-bit, single-step shifter with a width-generic, counted, handshaked block.

## Interface
- `WIDTH`, 8, register width in bits (≥2).
- `AMT_W`, 4, width of shift-amount field; max steps per command = 2^AMT_W − 1.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command; combinational `!busy`.
- `op` input 3: operation, sampled on accept.
- `amt` input AMT_W: number of single-bit shift steps, sampled on accept.
- `din` input WIDTH: parallel load data, sampled on accept.
- `sin_r` input 1: serial in, enters MSB on SRL.
- `sin_l` input 1: serial in, enters LSB on SLL.
- `q` output WIDTH: register contents.
- `sout_r` output 1: `q[0]`, combinational.
- `sout_l` output 1: `q[WIDTH-1]`, combinational.
- `busy` output 1: multi-step shift in progress.
- `done` output 1: one-cycle pulse on command completion.

## Operation
- Accept = `cmd_valid && cmd_ready` at a rising edge (edge k). Commands offered while busy are ignored and not queued.
- `op` encoding:
  - 000 NOP: no change.
  - 001 SRL: shift toward LSB; MSB filled with the fill bit.
  - 010 SLL: shift toward MSB; LSB filled with the fill bit.
  - 011 LOAD: `q <= din`.
  - 100 ROR: rotate toward LSB.
  - 101 ROL: rotate toward MSB.
  - 110 SRA: shift toward LSB; MSB replicates the current `q[WIDTH-1]`.
  - 111 CLEAR: `q <= 0`.
- `amt` is ignored for NOP, LOAD and CLEAR. These complete at edge k.
- Shift ops with `amt = N`:
  - N = 0: no change; completes at edge k.
  - N ≥ 1: one step at each of edges k … k+N−1. The op is latched internally. The serial inputs are sampled at each step edge.
  - A step counter is loaded with N−1 at accept and decrements each step.
- States:
  - IDLE → SHIFT on accept of a shift op with N ≥ 2.
  - SHIFT → IDLE when the counter reaches 0 at a step edge.
  - All other accepts remain in IDLE.
- `busy` = 1 in SHIFT only.
- `done` pulses for exactly the one cycle following the completing edge.
- Shift amounts greater than WIDTH are legal and simply perform more steps. SRL/SLL saturate to all-fill, rotates wrap modulo WIDTH, SRA saturates to all-sign.
- Reset at any time, including mid-shift:
  - `q = 0`, `busy = 0`, `done = 0`, counter = 0, state IDLE, so `cmd_ready = 1`.
  - The aborted command produces no `done`.

## Timing
- Reset values: `q = 0`, `busy = 0`, `done = 0`, `cmd_ready = 1`, `sout_r = 0`, `sout_l = 0`.
- `q`, `busy` and `done` are registered. `cmd_ready`, `sout_r` and `sout_l` are combinational from registers only, with no input-to-output paths.
- Latency from accept edge to `done` high:
  - 1 cycle for NOP, LOAD, CLEAR and N ≤ 1.
  - N cycles for N ≥ 1.
- Throughput: for N ≥ 2, a new command may be accepted in the same cycle `done` is high, because `busy` is already 0. This gives back-to-back commands with no idle cycle.
- `busy` rises after edge k and falls after edge k+N−1.

## Configuration
- Macro: `USR_SERIAL_IN_EN`.
- Defined: the SRL fill bit is `sin_r` and the SLL fill bit is `sin_l`, each sampled at its step edge.
- Undefined: the SRL and SLL fill bit is 0, and `sin_r`/`sin_l` are ignored. The ports remain present so the port list is identical in both builds.
- ROR, ROL, SRA, LOAD, CLEAR and NOP are unaffected either way.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `q = 0x00`, `busy = 0`, `done = 0`, `cmd_ready = 1` immediately, without waiting for a clock edge.
- **LOAD then ROR:** WIDTH=8, LOAD `din = 0x81`, then ROR `amt = 3`:
  - LOAD: `done` high 1 cycle after accept.
  - ROR: `q = 0xC0`, then `0x60`, then `0x30`; `busy` high 2 cycles; `done` pulses after the 3rd step; `cmd_ready` low while busy.
- **SRA:** load `0x90`, SRA `amt = 2` → `q = 0xE4`, `done` 2 cycles after accept.
- **SLL fill:** load `0x81`, `sin_l = 1`, SLL `amt = 1`:
  - Built with `USR_SERIAL_IN_EN`: `q = 0x03`, `sout_l = 0`.
  - Built without it: `q = 0x02`.
- **Busy and back-to-back:** load `0xA5`, SRL `amt = 4` with zero fill → `q = 0x0A`:
  - `cmd_valid` held with a LOAD `0x55` while busy is not accepted.
  - The LOAD is accepted in the cycle `done` is high, and `q = 0x55` next cycle.
- **Reset mid-operation:** load `0xFF`, SRL `amt = 5`, assert `rst` after 2 steps → `q = 0x00`, `busy = 0`, no `done` pulse. A subsequent LOAD `0x3C` is accepted normally.
